piso_shift_tx: RTL
==================

PISO_SHIFT_TX -- requirements
Module: piso_shift_tx

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning the number of data bits per word (legal range 2..32).
REQ-002 The block SHALL have parameter MSB_FIRST, default 0, meaning shift order: 0 = LSB first, 1 = MSB first.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port clr  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port din  input  WIDTH  parallel word to transmit.
REQ-006 The block SHALL have port load_valid  input  1  din is valid and offered for transmission.
REQ-007 The block SHALL have port load_ready  output  1  block accepts a word this cycle.
REQ-008 The block SHALL have port SDO  output  1  serial data out.
REQ-009 The block SHALL have port sdo_valid  output  1  SDO carries a frame bit this cycle.
REQ-010 The block SHALL have port busy  output  1  a frame is in progress.
REQ-011 The block SHALL have port done  output  1  one-cycle pulse marking the final bit of a frame.

Function
REQ-012 The block SHALL implement states IDLE and SHIFT; IDLE -> SHIFT on handshake; SHIFT -> IDLE after the last frame bit unless a new handshake occurs in that cycle.
REQ-013 A handshake SHALL occur on any rising edge where load_valid and load_ready are both high; din SHALL be captured into an internal shift register on that edge.
REQ-014 load_ready SHALL be high in IDLE and in the last-bit cycle of SHIFT, and low otherwise (combinational from state and bit counter).
REQ-015 The first frame bit SHALL appear on SDO with sdo_valid high in the cycle immediately after the handshake (latency 1).
REQ-016 With MSB_FIRST=0 bits SHALL be emitted din[0] first through din[WIDTH-1]; with MSB_FIRST=1, din[WIDTH-1] first through din[0]; one bit per cycle, no gaps.
REQ-017 A bit counter of ceil(log2(WIDTH+1)) bits SHALL track frame position, clear on handshake, and never exceed the frame length minus one.
REQ-018 done SHALL be high exactly in the cycle the last frame bit is on SDO.
REQ-019 Back-to-back: a handshake in the last-bit cycle SHALL make the next frame's first bit follow with no idle cycle; busy SHALL stay high throughout.
REQ-020 load_valid while load_ready is low SHALL be ignored; din changes during SHIFT SHALL not affect the frame in progress.
REQ-021 In IDLE, SDO SHALL be 0, sdo_valid 0, busy 0, done 0.
REQ-022 busy SHALL equal (state == SHIFT); sdo_valid SHALL equal busy.

Reset
REQ-023 When clr is high at a rising edge, the state SHALL go to IDLE, the shift register and counter to 0, and SDO, sdo_valid, busy and done to 0 in the following cycle, regardless of state.
REQ-024 clr SHALL take priority over a simultaneous handshake; the word offered in that cycle SHALL be discarded.
REQ-025 A frame interrupted by clr SHALL be abandoned, not resumed; done SHALL not pulse for it.

Configuration
REQ-026 With macro PISO_PARITY_EN defined, the frame SHALL be WIDTH+1 bits: data bits, then one even-parity bit (XOR of din); done and the last-bit load_ready window SHALL move to the parity cycle.
REQ-027 Without PISO_PARITY_EN, the frame SHALL be exactly WIDTH bits and no parity logic SHALL exist.

Verification
REQ-028 WIDTH=4, MSB_FIRST=0, clr released, din=4'b1011 with one-cycle load_valid -> SDO 1,1,0,1 on cycles 1..4, sdo_valid high cycles 1..4, done high on cycle 4 only.
REQ-029 MSB_FIRST=1, din=4'b1011 -> SDO 1,0,1,1; then IDLE with SDO=0.
REQ-030 Back-to-back: din=4'b0001 then 4'b1110, load_valid held high -> SDO 1,0,0,0,0,1,1,1 contiguous, busy high for 8 cycles, done on cycles 4 and 8.
REQ-031 clr asserted in bit cycle 2 of din=4'b1111 -> next cycle SDO=0, sdo_valid=0, busy=0, no done; a new word loads normally afterwards.
REQ-032 din changed to 4'b0000 and load_valid pulsed during the frame of 4'b1010 -> SDO 0,1,0,1 unaffected, load_ready low in cycles 1..3.
REQ-033 PISO_PARITY_EN defined, din=4'b1011 -> SDO 1,1,0,1,1 (parity 1), done on cycle 5; din=4'b0011 -> parity bit 0.

Source files
------------

// File: rtl/piso_shift_tx.sv
// piso_shift_tx: parallel-in serial-out transmitter with valid/ready load and back-to-back framing.
// Define PISO_PARITY_EN to append an even-parity bit to every frame.
module piso_shift_tx #(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             SDO,
    output logic             sdo_valid,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH + 1);
`ifdef PISO_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic             last, hs, data_bit;

    assign last       = cnt_q == LAST;
    assign busy       = state_q == SHIFT;
    assign sdo_valid  = busy;
    assign load_ready = !busy || last;
    assign done       = busy && last;
    assign hs         = load_valid && load_ready;
    assign data_bit   = (MSB_FIRST != 0) ? sr_q[WIDTH-1] : sr_q[0];

`ifdef PISO_PARITY_EN
    logic par_q, par_d;

    assign par_d = hs ? ^din : par_q;
    assign SDO   = busy && ((cnt_q == CW'(WIDTH)) ? par_q : data_bit);

    always_ff @(posedge clk) begin
        if (clr) par_q <= 1'b0;
        else     par_q <= par_d;
    end
`else
    assign SDO = busy && data_bit;
`endif

    // The outgoing bit always sits at the shift-out end, so each frame bit just shifts toward it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        if (hs) begin
            state_d = SHIFT;
            cnt_d   = '0;
            sr_d    = din;
        end else if (busy) begin
            state_d = last ? IDLE : SHIFT;
            cnt_d   = last ? '0 : cnt_q + CW'(1);
            sr_d    = (MSB_FIRST != 0) ? (sr_q << 1) : (sr_q >> 1);
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
        end
    end
endmodule
